gray_to_binary_tracker: RTL

- Receiving end of the 3-bit binary-to-Gray path: accepts a stream of Gray-coded samples with a valid strobe and decodes each to binary.
- Tracks position between samples: reports single-step direction (up/down), flags illegal multi-step jumps, and keeps a signed wrap (revolution) count.
- Sits behind a Gray-coded source, such as a position encoder or an async-FIFO pointer. Feeds control logic that needs binary position plus motion events.

---
 rtl/gray_to_binary_tracker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gray_to_binary_tracker.sv
// Gray-code sample decoder with step-direction, jump-error and revolution tracking.
// Each accepted sample becomes the reference for classifying the next one.
module gray_to_binary_tracker #(
  parameter int WIDTH = 3,
  parameter int REV_W = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   g_in,
  input  logic               g_valid_in,
  output logic [WIDTH-1:0]   b_out,
  output logic               b_valid_out,
  output logic               up_out,
  output logic               down_out,
  output logic               err_out,
  output logic [REV_W-1:0]   rev_out,
  output logic [7:0]         err_cnt_out,
  output logic               locked_out
);

  typedef enum logic {EMPTY = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [WIDTH-1:0] B_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] B_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] B_MAX  = {WIDTH{1'b1}};
  localparam logic [REV_W-1:0] R_ONE  = {{(REV_W-1){1'b0}}, 1'b1};

  // Prefix-XOR from the MSB down turns a Gray code into binary.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic             b_valid_r, b_valid_s;
  logic             up_r, up_s;
  logic             down_r, down_s;
  logic             err_r, err_s;
  logic [REV_W-1:0] rev_r, rev_s;
  logic [7:0]       err_cnt_r, err_cnt_s;
  logic [WIDTH-1:0] b_new_s;
  logic [WIDTH-1:0] diff_s;

  assign b_new_s = gray_to_bin(g_in);
  assign diff_s  = b_new_s - b_r;

  // Next-state and next-output computation for one accepted sample.
  always_comb begin
    state_s   = state_r;
    b_s       = b_r;
    b_valid_s = 1'b0;
    up_s      = 1'b0;
    down_s    = 1'b0;
    err_s     = 1'b0;
    rev_s     = rev_r;
    err_cnt_s = err_cnt_r;
    if (g_valid_in) begin
      b_s       = b_new_s;
      b_valid_s = 1'b1;
      case (state_r)
        EMPTY: begin
          state_s = LOCK;
        end
        LOCK: begin
          if (diff_s == B_ZERO) begin
            state_s = LOCK;
          end else if (diff_s == B_ONE) begin
            up_s = 1'b1;
            if (b_r == B_MAX) begin
              rev_s = rev_r + R_ONE;
            end else begin
              rev_s = rev_r;
            end
          end else if (diff_s == B_MAX) begin
            down_s = 1'b1;
            if (b_r == B_ZERO) begin
              rev_s = rev_r - R_ONE;
            end else begin
              rev_s = rev_r;
            end
          end else begin
            // Illegal jump: resynchronise to the new sample, no revolution change.
            err_s = 1'b1;
            if (err_cnt_r != 8'hFF) begin
              err_cnt_s = err_cnt_r + 8'd1;
            end else begin
              err_cnt_s = err_cnt_r;
            end
          end
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= EMPTY;
      b_r       <= B_ZERO;
      b_valid_r <= 1'b0;
      up_r      <= 1'b0;
      down_r    <= 1'b0;
      err_r     <= 1'b0;
      rev_r     <= {REV_W{1'b0}};
      err_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_s;
      b_r       <= b_s;
      b_valid_r <= b_valid_s;
      up_r      <= up_s;
      down_r    <= down_s;
      err_r     <= err_s;
      rev_r     <= rev_s;
      err_cnt_r <= err_cnt_s;
    end
  end

  assign b_out       = b_r;
  assign b_valid_out = b_valid_r;
  assign up_out      = up_r;
  assign down_out    = down_r;
  assign err_out     = err_r;
  assign rev_out     = rev_r;
  assign err_cnt_out = err_cnt_r;
  assign locked_out  = (state_r == LOCK);

endmodule
